ssd_window_acc: RTL and testbench

Multi-lane, windowed sum-of-squared-differences engine for the stereo matching datapath. Each beat carries LANES unsigned pixel pairs. Per lane it forms (a−b)², sums the lanes, and accumulates over a window of WIN beats (or up to an early `in_last`). It emits one SSD cost per window with a valid pulse. It replaces single-lane squared-difference multipliers in the cost-aggregation stage.

---
 rtl/ssd_window_acc.sv | 171 +++++++++++++++++
 tb/tb_ssd_window_acc.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_window_acc.sv
// Five-stage, multi-lane windowed sum-of-squared-differences accumulator.
// Optional build macro SSD_SATURATE_EN: clamp acc/ssd_out at 2^ACCW-1 on overflow instead of wrapping.
module ssd_window_acc #(
    parameter int SIZEIN = 16,
    parameter int LANES  = 4,
    parameter int WIN    = 64,
    parameter int ACCW   = 40
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic [LANES*SIZEIN-1:0] a,
    input  logic [LANES*SIZEIN-1:0] b,
    output logic [ACCW-1:0]         ssd_out,
    output logic                    ssd_valid,
    output logic                    ssd_ovf
);

    localparam int SQW  = 2 * SIZEIN;
    localparam int CNTW = (WIN > 1) ? $clog2(WIN) : 1;

    // Index 0 is S1 ... index 3 is S4; S5 is the accumulator itself.
    logic [3:0] vld_q, vld_d;
    logic [3:0] last_q, last_d;

    logic [LANES*SQW-1:0] sq_flat;

    logic [ACCW-1:0] lane_sum_q, lane_sum_d;
    logic [ACCW-1:0] lane_sum_comb;

    logic [ACCW-1:0] acc_q, acc_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            ovf_sticky_q, ovf_sticky_d;
    logic [ACCW-1:0] ssd_out_q, ssd_out_d;
    logic            ssd_valid_q, ssd_valid_d;
    logic            ssd_ovf_q, ssd_ovf_d;

    logic [ACCW:0]   sum_full;
    logic            carry;
    logic [ACCW-1:0] acc_sum;
    logic            close;

    always_comb begin
        vld_d  = vld_q;
        last_d = last_q;
        if (ce) begin
            vld_d  = {vld_q[2:0], in_valid};
            last_d = {last_q[2:0], in_last};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= '0;
            last_q <= '0;
        end else begin
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [SIZEIN-1:0]     a_q, a_d;
            logic [SIZEIN-1:0]     b_q, b_d;
            logic signed [SIZEIN:0] diff_q, diff_d;
            logic [SIZEIN-1:0]     mag;
            logic [SQW-1:0]        sq_q, sq_d;

            always_comb begin
                a_d    = a_q;
                b_d    = b_q;
                diff_d = diff_q;
                sq_d   = sq_q;
                // |diff| always fits in SIZEIN bits, so square the magnitude unsigned.
                mag    = SIZEIN'(diff_q[SIZEIN] ? -diff_q : diff_q);
                if (ce) begin
                    a_d    = a[gi*SIZEIN +: SIZEIN];
                    b_d    = b[gi*SIZEIN +: SIZEIN];
                    diff_d = $signed({1'b0, a_q}) - $signed({1'b0, b_q});
                    sq_d   = SQW'(mag) * SQW'(mag);
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q    <= '0;
                    b_q    <= '0;
                    diff_q <= '0;
                    sq_q   <= '0;
                end else begin
                    a_q    <= a_d;
                    b_q    <= b_d;
                    diff_q <= diff_d;
                    sq_q   <= sq_d;
                end
            end

            assign sq_flat[gi*SQW +: SQW] = sq_q;
        end
    endgenerate

    always_comb begin
        lane_sum_comb = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum_comb = lane_sum_comb + ACCW'(sq_flat[i*SQW +: SQW]);
        end
        lane_sum_d = ce ? lane_sum_comb : lane_sum_q;
    end

    always_comb begin
        sum_full = {1'b0, acc_q} + {1'b0, lane_sum_q};
        carry    = sum_full[ACCW];
`ifdef SSD_SATURATE_EN
        // Once clamped, the window stays pinned at full scale.
        acc_sum  = (carry || ovf_sticky_q) ? '1 : sum_full[ACCW-1:0];
`else
        acc_sum  = sum_full[ACCW-1:0];
`endif
        close    = vld_q[3] && ((cnt_q == CNTW'(WIN - 1)) || last_q[3]);

        acc_d        = acc_q;
        cnt_d        = cnt_q;
        ovf_sticky_d = ovf_sticky_q;
        ssd_out_d    = ssd_out_q;
        ssd_ovf_d    = ssd_ovf_q;
        ssd_valid_d  = 1'b0;

        if (ce && vld_q[3]) begin
            if (close) begin
                ssd_out_d    = acc_sum;
                ssd_ovf_d    = ovf_sticky_q | carry;
                ssd_valid_d  = 1'b1;
                acc_d        = '0;
                cnt_d        = '0;
                ovf_sticky_d = 1'b0;
            end else begin
                acc_d        = acc_sum;
                cnt_d        = cnt_q + CNTW'(1);
                ovf_sticky_d = ovf_sticky_q | carry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_sum_q   <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_sticky_q <= 1'b0;
            ssd_out_q    <= '0;
            ssd_valid_q  <= 1'b0;
            ssd_ovf_q    <= 1'b0;
        end else begin
            lane_sum_q   <= lane_sum_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_sticky_q <= ovf_sticky_d;
            ssd_out_q    <= ssd_out_d;
            ssd_valid_q  <= ssd_valid_d;
            ssd_ovf_q    <= ssd_ovf_d;
        end
    end

    assign ssd_out   = ssd_out_q;
    assign ssd_valid = ssd_valid_q;
    assign ssd_ovf   = ssd_ovf_q;

endmodule

// File: tb/tb_ssd_window_acc.sv
// Scoreboarded bench for ssd_window_acc: beat-level window model feeds an expectation queue.
module tb_ssd_window_acc;

    localparam int SIZEIN = 16;
    localparam int LANES  = 4;
    localparam int WIN    = 4;
    localparam int ACCW   = 34;
    localparam int W      = LANES * SIZEIN;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ce = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_last = 1'b0;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic [ACCW-1:0] ssd_out;
    logic            ssd_valid;
    logic            ssd_ovf;

    ssd_window_acc #(.SIZEIN(SIZEIN), .LANES(LANES), .WIN(WIN), .ACCW(ACCW)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_last(in_last),
        .a(a), .b(b), .ssd_out(ssd_out), .ssd_valid(ssd_valid), .ssd_ovf(ssd_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ACCW-1:0] out;
        logic            ovf;
        longint          due;
    } exp_t;

    exp_t   exp_q[$];
    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;
    longint ce_edges = 0;
    longint close_cyc = 0;
    longint last_pulse_cyc = 0;
    longint spacing = 0;
    int     pulses = 0;
    logic [ACCW-1:0] last_dut_out = '0;
    logic            last_dut_ovf = 1'b0;
    logic [ACCW-1:0] last_exp_out = '0;

    longint unsigned win_sum = 0;
    int              win_cnt = 0;
    longint unsigned mask = (64'd1 << ACCW) - 64'd1;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (ce && rst_n) ce_edges = ce_edges + 1;
    end

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end else begin
            $display("ok   %s value=0x%0h", name, act);
        end
    endtask

    // Monitor: pop one expectation per pulse; an overdue expectation is a timeout.
    always @(negedge clk) begin
        if (ssd_valid) begin
            exp_t e;
            pulses++;
            spacing = cyc - last_pulse_cyc;
            last_pulse_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_pulse actual=1 required=0 out=0x%0h", ssd_out);
            end else begin
                e = exp_q.pop_front();
                last_dut_out = ssd_out;
                last_dut_ovf = ssd_ovf;
                last_exp_out = e.out;
                check("pulse_out", 64'(ssd_out), 64'(e.out));
                check("pulse_ovf", 64'(ssd_ovf), 64'(e.ovf));
                check("pulse_latency", 64'(ce_edges), 64'(e.due));
            end
        end else if (exp_q.size() > 0 && ce_edges > exp_q[0].due) begin
            checks++;
            failures++;
            $display("FAIL pulse_timeout actual=none required=pulse at ce_edge %0d", exp_q[0].due);
            void'(exp_q.pop_front());
        end
    end

    function automatic longint unsigned beat_ss(input logic [W-1:0] av, input logic [W-1:0] bv);
        longint unsigned s = 0;
        for (int i = 0; i < LANES; i++) begin
            longint d = longint'(av[i*SIZEIN +: SIZEIN]) - longint'(bv[i*SIZEIN +: SIZEIN]);
            s += longint'(d * d);
        end
        return s;
    endfunction

    task automatic push_close();
        exp_t e;
        e.ovf = (win_sum > mask);
`ifdef SSD_SATURATE_EN
        e.out = e.ovf ? ACCW'(mask) : ACCW'(win_sum);
`else
        e.out = ACCW'(win_sum & mask);
`endif
        e.due = ce_edges + 4;
        exp_q.push_back(e);
        close_cyc = cyc;
        win_sum = 0;
        win_cnt = 0;
    endtask

    task automatic step(input logic c, input logic v, input logic l,
                        input logic [W-1:0] av, input logic [W-1:0] bv);
        ce = c; in_valid = v; in_last = l; a = av; b = bv;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            win_sum = 0;
            win_cnt = 0;
        end else if (c && v) begin
            win_sum += beat_ss(av, bv);
            win_cnt++;
            if (win_cnt == WIN || l) push_close();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b1;
    endtask

    function automatic logic [W-1:0] pack4(input int v0, input int v1, input int v2, input int v3);
        logic [W-1:0] r;
        r = {SIZEIN'(v3), SIZEIN'(v2), SIZEIN'(v1), SIZEIN'(v0)};
        return r;
    endfunction

    logic [W-1:0] va, vb, vmax;
    int p0;

    initial begin
        va   = pack4(10, 20, 30, 40);
        vb   = pack4(7, 25, 30, 0);
        vmax = pack4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);

        do_reset(3);
        check("reset_out", 64'(ssd_out), 0);
        check("reset_valid", 64'(ssd_valid), 0);
        check("reset_ovf", 64'(ssd_ovf), 0);

        p0 = pulses;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, '0, '0);
        idle(12);
        check("zero_pulse_count", 64'(pulses - p0), 2);
        do_reset(1);
        idle(2);

        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, va, vb);
        idle(10);
        check("basic_out", 64'(last_dut_out), 6536);
        check("basic_latency", 64'(last_pulse_cyc - close_cyc), 4);

        step(1'b1, 1'b1, 1'b0, va, vb);
        idle(2);
        step(1'b1, 1'b1, 1'b0, va, vb);
        idle(1);
        step(1'b1, 1'b1, 1'b1, va, vb);
        idle(10);
        check("early_last_out", 64'(last_dut_out), 4902);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, va, vb);
        idle(10);
        check("after_last_out", 64'(last_dut_out), 6536);

        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, va, vb);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1, vmax, '0);
        idle(10);
        check("stall_out", 64'(last_dut_out), 6536);
        check("stall_latency", 64'(last_pulse_cyc - close_cyc), 11);

        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, va, vb);
        idle(4);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        check("valid_clears_ce0", 64'(ssd_valid), 0);
        idle(8);

        p0 = pulses;
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, vmax, '0);
        do_reset(1);
        idle(10);
        check("midreset_no_pulse", 64'(pulses - p0), 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, va, vb);
        idle(10);
        check("midreset_next_out", 64'(last_dut_out), 6536);
        check("midreset_next_ovf", 64'(last_dut_ovf), 0);

        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, va, vb);
        idle(10);
        check("b2b_spacing", 64'(spacing), WIN);

        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, vmax, '0);
        idle(10);
`ifdef SSD_SATURATE_EN
        check("ovf_out", 64'(last_dut_out), 64'h3_FFFF_FFFF);
`else
        check("ovf_out", 64'(last_dut_out), 64'h3_FFE0_0010);
`endif
        check("ovf_flag", 64'(last_dut_ovf), 1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, va, vb);
        idle(10);
        check("ovf_cleared", 64'(last_dut_ovf), 0);

        for (int n = 0; n < 400; n++) begin
            logic [W-1:0] ra, rb;
            for (int i = 0; i < LANES; i++) begin
                ra[i*SIZEIN +: SIZEIN] = SIZEIN'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 255));
                rb[i*SIZEIN +: SIZEIN] = SIZEIN'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 255));
            end
            step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 10, ra, rb);
        end
        // Flush a partial random window with an explicit last.
        step(1'b1, 1'b1, 1'b1, va, vb);
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) idle(1);
        idle(3);
        check("queue_drained", 64'(exp_q.size()), 0);
        check("hold_out", 64'(ssd_out), 64'(last_exp_out));
        check("hold_valid_low", 64'(ssd_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
